instr_loader: RTL and testbench

Boot-time program loader that sits directly upstream of the CPU and its instruction memory. It accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. It writes the words into instruction memory, one word per address, starting at word 0. It holds the CPU halted until the load completes, so program loading no longer depends on a bench-side memory preload.

---
 rtl/instr_loader.sv | 103 ++++++++++
 tb/tb_instr_loader.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// Boot-time program loader: assembles big-endian 32-bit words from a byte stream,
// writes them to instruction memory from word 0, and holds the CPU until done.
module instr_loader #(
    parameter int INSTR_MEM_SIZE = 32,
    parameter int ADDR_WIDTH     = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_byte,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_run,
    output logic                  done,
    output logic                  error
);

    localparam logic [7:0] MAX_N = 8'(INSTR_MEM_SIZE);

    typedef enum logic [2:0] {
        HEADER,
        BYTES,
        WRITE,
        DONE,
        ERROR
    } state_t;

    state_t      state;
    logic [1:0]  byte_idx;
    logic [7:0]  word_idx;
    logic [7:0]  count;
    logic [23:0] shreg;
    logic        xfer;

    // Gated by reset so no byte is taken while reset is asserted.
    assign in_ready = !reset && ((state == HEADER) || (state == BYTES));
    assign xfer     = in_valid && in_ready;
    assign cpu_run  = done;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= HEADER;
            byte_idx   <= '0;
            word_idx   <= '0;
            count      <= '0;
            shreg      <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                HEADER: begin
                    if (xfer) begin
                        count <= in_byte;
                        if (in_byte == 8'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else if (in_byte > MAX_N) begin
                            state <= ERROR;
                            error <= 1'b1;
                        end else begin
                            state <= BYTES;
                        end
                    end
                end
                BYTES: begin
                    if (xfer) begin
                        shreg <= {shreg[15:0], in_byte};
                        if (byte_idx == 2'd3) begin
                            // Write pulse and its address/data are registered together,
                            // so they stay stable for the whole WRITE cycle.
                            byte_idx   <= '0;
                            imem_we    <= 1'b1;
                            imem_addr  <= ADDR_WIDTH'(word_idx);
                            imem_wdata <= {shreg, in_byte};
                            state      <= WRITE;
                        end else begin
                            byte_idx <= byte_idx + 2'd1;
                        end
                    end
                end
                WRITE: begin
                    if (word_idx == count - 8'd1) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        word_idx <= word_idx + 8'd1;
                        state    <= BYTES;
                    end
                end
                DONE:    state <= DONE;
                ERROR:   state <= ERROR;
                default: state <= HEADER;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed testbench for instr_loader: drives byte streams and checks memory writes and status.
module tb_instr_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_ready;
    logic        imem_we;
    logic [4:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_run;
    logic        done;
    logic        error;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int xfer_cyc = 0;
    int          wq_addr[$];
    logic [31:0] wq_data[$];

    instr_loader #(.INSTR_MEM_SIZE(32), .ADDR_WIDTH(5)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_byte(in_byte),
        .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .cpu_run(cpu_run), .done(done), .error(error)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (imem_we === 1'b1) begin
            wq_addr.push_back(int'(imem_addr));
            wq_data.push_back(imem_wdata);
        end
    end

    // Offer one byte starting at a negedge; returns after the accepting edge.
    task automatic send(input logic [7:0] b);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_byte  = b;
        for (int k = 0; k < 100 && !acc; k++) begin
            acc = in_ready;
            if (acc) xfer_cyc = cyc + 1;
            @(negedge clock);
        end
        in_valid = 1'b0;
        total++;
        if (!acc) begin
            bad++;
            $display("FAIL send_timeout byte=%h not accepted", b);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        wq_addr.delete();
        wq_data.delete();
        @(negedge clock);
    endtask

    task automatic wait_done();
        for (int k = 0; k < 200 && done !== 1'b1; k++) @(negedge clock);
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL done_timeout done=%b exp=1", done);
        end
    endtask

    task automatic check_basic_writes(input string tag);
        logic [31:0] exp [3];
        exp[0] = 32'h8C080000;
        exp[1] = 32'h00094020;
        exp[2] = 32'hAC110004;
        total++;
        if (wq_data.size() != 3) begin
            bad++;
            $display("FAIL %s_wcount got=%0d exp=3", tag, wq_data.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (wq_addr[i] != i || wq_data[i] !== exp[i]) begin
                    bad++;
                    $display("FAIL %s_word%0d got addr=%0d data=%h exp addr=%0d data=%h",
                             tag, i, wq_addr[i], wq_data[i], i, exp[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        in_valid = 1'b1;
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        total++;
        if ({in_ready, imem_we, cpu_run, done, error} !== 5'b0 || imem_addr !== 5'd0 || imem_wdata !== 32'd0) begin
            bad++;
            $display("FAIL reset_outputs got rdy=%b we=%b run=%b done=%b err=%b addr=%h data=%h exp all 0",
                     in_ready, imem_we, cpu_run, done, error, imem_addr, imem_wdata);
        end
        in_valid = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_header_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_basic();
        logic [7:0] s [12] = '{8'h8C, 8'h08, 8'h00, 8'h00, 8'h00, 8'h09, 8'h40, 8'h20,
                               8'hAC, 8'h11, 8'h00, 8'h04};
        int hdr;
        do_reset();
        send(8'h03);
        hdr = xfer_cyc;
        for (int i = 0; i < 12; i++) begin
            send(s[i]);
            if (i == 3) begin
                total++;
                if (in_ready !== 1'b0 || imem_we !== 1'b1 || imem_addr !== 5'd0 || imem_wdata !== 32'h8C080000) begin
                    bad++;
                    $display("FAIL basic_write_cycle got rdy=%b we=%b addr=%h data=%h exp 0 1 00 8c080000",
                             in_ready, imem_we, imem_addr, imem_wdata);
                end
            end
        end
        total++;
        if (done !== 1'b0) begin
            bad++;
            $display("FAIL basic_done_early got=%b exp=0", done);
        end
        wait_done();
        total++;
        if (cyc - hdr != 15) begin
            bad++;
            $display("FAIL basic_latency got=%0d exp=15", cyc - hdr);
        end
        total++;
        if (cpu_run !== 1'b1 || error !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL basic_status got run=%b err=%b rdy=%b exp 1 0 0", cpu_run, error, in_ready);
        end
        check_basic_writes("basic");
    endtask

    task automatic test_back_to_back_gaps();
        logic [7:0] s [12] = '{8'h8C, 8'h08, 8'h00, 8'h00, 8'h00, 8'h09, 8'h40, 8'h20,
                               8'hAC, 8'h11, 8'h00, 8'h04};
        do_reset();
        send(8'h03);
        idle(2);
        for (int i = 0; i < 12; i++) begin
            send(s[i]);
            idle(2);
        end
        wait_done();
        check_basic_writes("gaps");
        // Extra bytes after DONE must never be taken.
        in_valid = 1'b1;
        in_byte  = 8'hFF;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            total++;
            if (in_ready !== 1'b0 || done !== 1'b1 || cpu_run !== 1'b1) begin
                bad++;
                $display("FAIL extra_after_done got rdy=%b done=%b run=%b exp 0 1 1", in_ready, done, cpu_run);
            end
        end
        in_valid = 1'b0;
        total++;
        if (wq_data.size() != 3) begin
            bad++;
            $display("FAIL extra_no_write got=%0d exp=3", wq_data.size());
        end
    endtask

    task automatic test_zero_count();
        do_reset();
        send(8'h00);
        total++;
        if (done !== 1'b1 || cpu_run !== 1'b1 || error !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL zero_status got done=%b run=%b err=%b rdy=%b exp 1 1 0 0", done, cpu_run, error, in_ready);
        end
        idle(3);
        total++;
        if (wq_data.size() != 0) begin
            bad++;
            $display("FAIL zero_no_write got=%0d exp=0", wq_data.size());
        end
    endtask

    task automatic test_overflow();
        do_reset();
        send(8'h21);
        in_valid = 1'b1;
        in_byte  = 8'h12;
        repeat (6) @(negedge clock);
        in_valid = 1'b0;
        total++;
        if (error !== 1'b1 || cpu_run !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL overflow_status got err=%b run=%b done=%b rdy=%b exp 1 0 0 0", error, cpu_run, done, in_ready);
        end
        total++;
        if (wq_data.size() != 0) begin
            bad++;
            $display("FAIL overflow_no_write got=%0d exp=0", wq_data.size());
        end
    endtask

    task automatic test_full_size();
        logic [31:0] w;
        do_reset();
        send(8'h20);
        for (int i = 0; i < 32; i++) begin
            w = {8'(i), 8'(i) ^ 8'hA5, 8'h5A, ~8'(i)};
            send(w[31:24]);
            send(w[23:16]);
            send(w[15:8]);
            send(w[7:0]);
        end
        wait_done();
        total++;
        if (wq_data.size() != 32 || error !== 1'b0) begin
            bad++;
            $display("FAIL full_wcount got=%0d err=%b exp=32 0", wq_data.size(), error);
        end else begin
            for (int i = 0; i < 32; i++) begin
                w = {8'(i), 8'(i) ^ 8'hA5, 8'h5A, ~8'(i)};
                total++;
                if (wq_addr[i] != i || wq_data[i] !== w) begin
                    bad++;
                    $display("FAIL full_word%0d got addr=%0d data=%h exp addr=%0d data=%h",
                             i, wq_addr[i], wq_data[i], i, w);
                end
            end
        end
    endtask

    task automatic test_midload_reset();
        do_reset();
        send(8'h02);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        send(8'h55); send(8'h66);
        reset = 1'b1;
        @(negedge clock);
        total++;
        if ({in_ready, imem_we, cpu_run, done, error} !== 5'b0 || imem_addr !== 5'd0 || imem_wdata !== 32'd0) begin
            bad++;
            $display("FAIL midreset_outputs got rdy=%b we=%b run=%b done=%b err=%b addr=%h data=%h exp all 0",
                     in_ready, imem_we, cpu_run, done, error, imem_addr, imem_wdata);
        end
        reset = 1'b0;
        wq_addr.delete();
        wq_data.delete();
        @(negedge clock);
        total++;
        if (in_ready !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL midreset_header got rdy=%b done=%b exp 1 0", in_ready, done);
        end
        send(8'h01);
        send(8'h00); send(8'h00); send(8'h00); send(8'h0C);
        wait_done();
        total++;
        if (wq_data.size() != 1 || wq_addr[0] != 0 || wq_data[0] !== 32'h0000000C) begin
            bad++;
            $display("FAIL midreset_reload got n=%0d addr=%0d data=%h exp n=1 addr=0 data=0000000c",
                     wq_data.size(), (wq_addr.size() > 0) ? wq_addr[0] : -1,
                     (wq_data.size() > 0) ? wq_data[0] : 32'hx);
        end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_basic();
        test_back_to_back_gaps();
        test_zero_count();
        test_overflow();
        test_full_size();
        test_midload_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
